// File: rtl/alu_muldiv_if.sv
// Operand, opcode and result bundle between the ID/EX operand muxes and the execute-stage ALU.
interface alu_muldiv_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
);
    logic [CTRL_W-1:0] ctrl;
    logic [WIDTH-1:0]  arg1;
    logic [WIDTH-1:0]  arg2;
    logic [4:0]        shamt;
    logic              start;
    logic [WIDTH-1:0]  result;
    logic              zero;
    logic              overflow;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    modport master (
        output ctrl, arg1, arg2, shamt, start,
        input  result, zero, overflow, busy, done, hi, lo
    );

    modport slave (
        input  ctrl, arg1, arg2, shamt, start,
        output result, zero, overflow, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS execute-stage ALU with an iterative multiply/divide unit driving HI/LO.
// Latency: ALU ops 0 cycles; mul/div write HI/LO WIDTH+1 edges after start (ALU_FAST_MUL_EN: multiply after 2).
// Backpressure: busy holds the pipeline; start, MTHI and MTLO are ignored while busy.
module alu_muldiv #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CTRL_W-1:0] OP_ADDU  = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] OP_ADD   = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_SUBU  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_SUB   = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] OP_AND   = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] OP_OR    = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] OP_XOR   = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] OP_NOR   = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] OP_SLT   = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] OP_SLTU  = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] OP_SLL   = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] OP_SRL   = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] OP_SRA   = CTRL_W'(12);
    localparam logic [CTRL_W-1:0] OP_LUI   = CTRL_W'(13);
    localparam logic [CTRL_W-1:0] OP_MFHI  = CTRL_W'(14);
    localparam logic [CTRL_W-1:0] OP_MFLO  = CTRL_W'(15);
    localparam logic [CTRL_W-1:0] OP_MTHI  = CTRL_W'(16);
    localparam logic [CTRL_W-1:0] OP_MTLO  = CTRL_W'(17);
    localparam logic [CTRL_W-1:0] OP_MULT  = CTRL_W'(18);
    localparam logic [CTRL_W-1:0] OP_MULTU = CTRL_W'(19);
    localparam logic [CTRL_W-1:0] OP_DIV   = CTRL_W'(20);
    localparam logic [CTRL_W-1:0] OP_DIVU  = CTRL_W'(21);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  hi_r, lo_r, hi_acc, lo_acc, b_mag, a_raw;
    logic              busy_r, done_r, op_div, a_neg, b_neg, b_zero;

    // ---------------- combinational ALU ----------------
    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf;

    assign sum     = bus.arg1 + bus.arg2;
    assign diff    = bus.arg1 - bus.arg2;
    assign add_ovf = (bus.arg1[WIDTH-1] == bus.arg2[WIDTH-1]) && (sum[WIDTH-1] != bus.arg1[WIDTH-1]);
    assign sub_ovf = (bus.arg1[WIDTH-1] != bus.arg2[WIDTH-1]) && (diff[WIDTH-1] != bus.arg1[WIDTH-1]);

    always_comb begin
        bus.result   = '0;
        bus.overflow = 1'b0;
        case (bus.ctrl)
            OP_ADDU: bus.result = sum;
            OP_ADD: begin
                bus.result   = sum;
                bus.overflow = add_ovf;
            end
            OP_SUBU: bus.result = diff;
            OP_SUB: begin
                bus.result   = diff;
                bus.overflow = sub_ovf;
            end
            OP_AND:  bus.result = bus.arg1 & bus.arg2;
            OP_OR:   bus.result = bus.arg1 | bus.arg2;
            OP_XOR:  bus.result = bus.arg1 ^ bus.arg2;
            OP_NOR:  bus.result = ~(bus.arg1 | bus.arg2);
            OP_SLT:  bus.result = {{(WIDTH-1){1'b0}}, $signed(bus.arg1) < $signed(bus.arg2)};
            OP_SLTU: bus.result = {{(WIDTH-1){1'b0}}, bus.arg1 < bus.arg2};
            OP_SLL:  bus.result = bus.arg2 << bus.shamt;
            OP_SRL:  bus.result = bus.arg2 >> bus.shamt;
            OP_SRA:  bus.result = $signed(bus.arg2) >>> bus.shamt;
            OP_LUI:  bus.result = bus.arg2 << (WIDTH / 2);
            OP_MFHI: bus.result = hi_r;
            OP_MFLO: bus.result = lo_r;
            default: ;
        endcase
    end

    assign bus.zero = (bus.arg1 == bus.arg2);
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // ---------------- mul/div datapath ----------------
    logic             md_op, md_signed, arg1_neg, arg2_neg, fast_skip;
    logic [WIDTH-1:0] arg1_mag, arg2_mag;

    assign md_op     = (bus.ctrl == OP_MULT) || (bus.ctrl == OP_MULTU) ||
                       (bus.ctrl == OP_DIV)  || (bus.ctrl == OP_DIVU);
    assign md_signed = (bus.ctrl == OP_MULT) || (bus.ctrl == OP_DIV);
    assign arg1_neg  = md_signed & bus.arg1[WIDTH-1];
    assign arg2_neg  = md_signed & bus.arg2[WIDTH-1];
    assign arg1_mag  = arg1_neg ? -bus.arg1 : bus.arg1;
    assign arg2_mag  = arg2_neg ? -bus.arg2 : bus.arg2;

    // Multiply: lo_acc holds the multiplier and shifts out as product bits shift in from hi_acc.
    logic [WIDTH:0]   mul_sum;
    // Divide: lo_acc holds the dividend and collects quotient bits; hi_acc is the partial remainder.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;

    assign mul_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, b_mag} : '0);
    assign div_shift = {hi_acc, lo_acc[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag};

    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef ALU_FAST_MUL_EN
    assign fast_skip = !op_div;
    assign prod_mag  = {{WIDTH{1'b0}}, lo_acc} * {{WIDTH{1'b0}}, b_mag};
`else
    assign fast_skip = 1'b0;
    assign prod_mag  = {hi_acc, lo_acc};
`endif

    assign prod_fix = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
    assign quo_fix  = (a_neg ^ b_neg) ? -lo_acc : lo_acc;
    assign rem_fix  = a_neg ? -hi_acc : hi_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            hi_acc <= '0;
            lo_acc <= '0;
            b_mag  <= '0;
            a_raw  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            op_div <= 1'b0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ctrl == OP_MTHI) hi_r <= bus.arg1;
                    if (bus.ctrl == OP_MTLO) lo_r <= bus.arg1;
                    if (bus.start && md_op) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        cnt    <= '0;
                        op_div <= (bus.ctrl == OP_DIV) || (bus.ctrl == OP_DIVU);
                        a_neg  <= arg1_neg;
                        b_neg  <= arg2_neg;
                        b_zero <= (bus.arg2 == '0);
                        b_mag  <= arg2_mag;
                        a_raw  <= bus.arg1;
                        hi_acc <= '0;
                        lo_acc <= arg1_mag;
                    end
                end
                RUN: begin
                    if (fast_skip) begin
                        state <= FIX;
                    end else begin
                        if (op_div) begin
                            if (!div_diff[WIDTH+1]) begin
                                hi_acc <= div_diff[WIDTH-1:0];
                                lo_acc <= {lo_acc[WIDTH-2:0], 1'b1};
                            end else begin
                                hi_acc <= div_shift[WIDTH-1:0];
                                lo_acc <= {lo_acc[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            {hi_acc, lo_acc} <= {mul_sum, lo_acc[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    if (op_div) begin
                        if (b_zero) begin
                            hi_r <= a_raw;
                            lo_r <= '1;
                        end else begin
                            hi_r <= rem_fix;
                            lo_r <= quo_fix;
                        end
                    end else begin
                        {hi_r, lo_r} <= prod_fix;
                    end
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv (WIDTH=32); multiply latency follows ALU_FAST_MUL_EN.
module tb_alu_muldiv;
    localparam int W = 32;
`ifdef ALU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    localparam logic [4:0] ADDU = 0, ADD = 1, SUBU = 2, SUB = 3, AND_ = 4, OR_ = 5, XOR_ = 6, NOR_ = 7;
    localparam logic [4:0] SLT = 8, SLTU = 9, SLL = 10, SRL = 11, SRA = 12, LUI = 13;
    localparam logic [4:0] MFHI = 14, MFLO = 15, MTHI = 16, MTLO = 17;
    localparam logic [4:0] MULT = 18, MULTU = 19, DIV = 20, DIVU = 21;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    alu_muldiv_if #(.WIDTH(W), .CTRL_W(5)) bus ();
    alu_muldiv #(.WIDTH(W), .CTRL_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu(input string tag, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] exp_res, input logic exp_ovf);
        @(negedge clk);
        bus.ctrl = c; bus.arg1 = a; bus.arg2 = b; bus.shamt = sh;
        #1;
        check({tag, "_res"}, 64'(bus.result), 64'(exp_res));
        check({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
    endtask

    // inj_kind: 0 none, 1 second start while busy, 2 MTLO while busy, 3 reset mid-op
    task automatic md(input string tag, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                      input int inj_k, input int inj_kind,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
        int first_done = -1;
        int busy_n = 0;
        int done_n = 0;
        int both_n = 0;
        logic [31:0] pre_lo;
        @(negedge clk);
        pre_lo = bus.lo;
        bus.ctrl = c; bus.arg1 = a; bus.arg2 = b; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.arg1 = 32'hA5A5_0F0F;
        bus.arg2 = 32'h3C3C_1234;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.busy) busy_n++;
            if (bus.done) done_n++;
            if (bus.busy && bus.done) both_n++;
            if (bus.done && first_done < 0) first_done = k;
            if (inj_kind == 1 && k == inj_k + 1) bus.start = 1'b0;
            if (inj_kind == 2 && k == inj_k + 1) begin
                check({tag, "_mtlo_busy"}, 64'(bus.lo), 64'(pre_lo));
                bus.ctrl = c;
            end
            if (k == inj_k && inj_kind == 1) begin
                bus.start = 1'b1; bus.ctrl = DIVU; bus.arg1 = 32'd50; bus.arg2 = 32'd7;
            end
            if (k == inj_k && inj_kind == 2) begin
                bus.ctrl = MTLO; bus.arg1 = 32'hDEAD_BEEF;
            end
            if (k == inj_k && inj_kind == 3) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_hi"}, 64'(bus.hi), 64'd0);
                check({tag, "_rst_lo"}, 64'(bus.lo), 64'd0);
                check({tag, "_rst_busy"}, 64'(bus.busy), 64'd0);
                check({tag, "_rst_done"}, 64'(bus.done), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (first_done >= 0 && k > first_done + 1) break;
        end
        check({tag, "_lat"}, 64'(first_done), 64'(exp_lat));
        check({tag, "_busy_cyc"}, 64'(busy_n), 64'(exp_lat));
        check({tag, "_done_cyc"}, 64'(done_n), 64'd1);
        check({tag, "_busy_and_done"}, 64'(both_n), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        rst_n = 1'b1;
        bus.ctrl = ADDU; bus.arg1 = '0; bus.arg2 = '0; bus.shamt = '0; bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        alu("add_ovf",  ADD,  32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 1'b1);
        alu("addu",     ADDU, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 1'b0);
        alu("sub_eq",   SUB,  32'd5, 32'd5, 0, 32'h0, 1'b0);
        check("sub_eq_zero", 64'(bus.zero), 64'd1);
        alu("sub_ovf",  SUB,  32'h8000_0000, 32'h1, 0, 32'h7FFF_FFFF, 1'b1);
        alu("subu",     SUBU, 32'h0, 32'h1, 0, 32'hFFFF_FFFF, 1'b0);
        check("subu_zero", 64'(bus.zero), 64'd0);
        alu("and",      AND_, 32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_F000, 1'b0);
        alu("or",       OR_,  32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_FFF0, 1'b0);
        alu("xor",      XOR_, 32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_0FF0, 1'b0);
        alu("nor",      NOR_, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 1'b0);
        alu("slt",      SLT,  32'hFFFF_FFFF, 32'h1, 0, 32'h1, 1'b0);
        alu("sltu",     SLTU, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1'b0);
        alu("sll",      SLL,  32'hFFFF_FFFF, 32'h1, 5'd31, 32'h8000_0000, 1'b0);
        alu("srl",      SRL,  32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
        alu("sra",      SRA,  32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
        alu("lui",      LUI,  32'h0, 32'h0000_1234, 0, 32'h1234_0000, 1'b0);
        alu("bad_op",   5'd25, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 32'h0, 1'b0);
        check("bad_op_zero", 64'(bus.zero), 64'd1);

        @(negedge clk);
        bus.ctrl = MTHI; bus.arg1 = 32'h1111_1111;
        @(negedge clk);
        bus.ctrl = MTLO; bus.arg1 = 32'h2222_2222;
        @(negedge clk);
        bus.ctrl = ADDU;
        check("mthi", 64'(bus.hi), 64'h1111_1111);
        check("mtlo", 64'(bus.lo), 64'h2222_2222);
        alu("mfhi", MFHI, 32'h0, 32'h0, 0, 32'h1111_1111, 1'b0);
        alu("mflo", MFLO, 32'h0, 32'h0, 0, 32'h2222_2222, 1'b0);

        md("mult_neg",   MULT,  32'hFFFF_FFFD, 32'd7, -1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        md("multu_max",  MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        md("div_neg",    DIV,   32'hFFFF_FFF9, 32'd2, -1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        md("div_negdiv", DIV,   32'd7, 32'hFFFF_FFFE, -1, 0, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT);
        md("divu_zero",  DIVU,  32'd100, 32'd0, -1, 0, 32'd100, 32'hFFFF_FFFF, DIV_LAT);
        md("div_minneg", DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 32'h0, 32'h8000_0000, DIV_LAT);
        md("divu_restart", DIVU, 32'd10, 32'd3, 5, 1, 32'd1, 32'd3, DIV_LAT);
        md("divu_mtlo",  DIVU,  32'd10, 32'd3, 5, 2, 32'd1, 32'd3, DIV_LAT);
        md("mult_rst",   MULT,  32'hFFFF_FFFD, 32'd7, 10, 3, 32'h0, 32'h0, MUL_LAT);
        md("multu_67",   MULTU, 32'd6, 32'd7, -1, 0, 32'h0, 32'd42, MUL_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
